// File: rtl/vadd_rr_scheduler.sv
// rtl/vadd_rr_scheduler.sv - round-robin sharing of one pipelined vector adder among NREQ requesters
// Requester IDs ride a tag pipeline that advances in lockstep with the adder's en.
module vadd_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int NREQ    = 2,
  parameter int LATENCY = 2,
  parameter int IDW     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*LANES*WIDTH-1:0]   req_a,
  input  logic [NREQ*LANES*WIDTH-1:0]   req_b,
  output logic [LANES*WIDTH-1:0]        add_a,
  output logic [LANES*WIDTH-1:0]        add_b,
  output logic                          add_en,
  input  logic [LANES*WIDTH-1:0]        add_y,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [IDW-1:0]                resp_id,
  output logic [LANES*WIDTH-1:0]        resp_y,
  output logic                          busy
);

  localparam int VW = LANES * WIDTH;

  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]     tag_id [LATENCY];
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     gnt_id;
  logic               found;
  logic               adv;
  logic               issue;

  // Only a valid head that the consumer refuses can stall; bubbles drain freely.
  assign adv    = !(tag_v[LATENCY-1] && !resp_ready);
  assign issue  = adv && found && reset;
  assign add_en = adv && reset;

  // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= ptr)) begin
        found  = 1'b1;
        gnt_id = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        gnt_id = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (gnt_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        add_a        = req_a[i*VW +: VW];
        add_b        = req_b[i*VW +: VW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_v <= '0;
      ptr   <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      if (adv) begin
        tag_v[0]  <= issue;
        tag_id[0] <= gnt_id;
        for (int k = 1; k < LATENCY; k++) begin
          tag_v[k]  <= tag_v[k-1];
          tag_id[k] <= tag_id[k-1];
        end
      end
      if (issue) begin
        if (gnt_id == IDW'(NREQ - 1)) begin
          ptr <= '0;
        end else begin
          ptr <= gnt_id + IDW'(1);
        end
      end
    end
  end

  assign resp_valid = tag_v[LATENCY-1] && reset;
  assign resp_id    = reset ? tag_id[LATENCY-1] : '0;
  assign resp_y     = add_y;
  assign busy       = (|tag_v) && reset;

endmodule
